// File: rtl/mult_div_pkg.sv
// Shared function codes, FSM encoding and divider constants for the MULT/DIV unit.
package mult_div_pkg;

  localparam logic [5:0] FunctMult  = 6'h18;
  localparam logic [5:0] FunctMultu = 6'h19;
  localparam logic [5:0] FunctDiv   = 6'h1A;
  localparam logic [5:0] FunctDivu  = 6'h1B;

  localparam int unsigned DivCycles = 32;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StDivBusy = 2'd1,
    StDivDone = 2'd2
  } state_e;

  // Magnitude of a value that is two's complement only when is_signed is set.
  function automatic logic [31:0] abs_val(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mult_div_core.sv
// Unsigned radix-2 restoring divider: one quotient bit per step, DivCycles steps.
module mult_div_core
  import mult_div_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        step,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        last,
  output logic [31:0] quotient_next,
  output logic [31:0] remainder_next
);

  localparam int unsigned CntW = $clog2(DivCycles);

  logic [31:0]     rem_q, quo_q, div_q;
  logic [CntW-1:0] cnt_q;
  logic [32:0]     trial;

  // Remainder stays below the divisor, so bit 32 of the trial is a clean borrow flag.
  assign trial = {rem_q, quo_q[31]} - {1'b0, div_q};
  assign last  = (cnt_q == CntW'(DivCycles - 1));

  always_comb begin
    quotient_next  = {quo_q[30:0], ~trial[32]};
    remainder_next = trial[32] ? {rem_q[30:0], quo_q[31]} : trial[31:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q <= '0;
      quo_q <= '0;
      div_q <= '0;
      cnt_q <= '0;
    end else if (start) begin
      rem_q <= '0;
      quo_q <= dividend;
      div_q <= divisor;
      cnt_q <= '0;
    end else if (step) begin
      rem_q <= remainder_next;
      quo_q <= quotient_next;
      cnt_q <= cnt_q + CntW'(1);
    end
  end

endmodule

// File: rtl/mult_div.sv
// HI/LO multiply/divide unit: single-cycle MULT/MULTU, multi-cycle stalling DIV/DIVU.
module mult_div
  import mult_div_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  func,
  input  logic [31:0] operand_1,
  input  logic [31:0] operand_2,
  input  logic        flush,
  output logic        stall_req,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  state_e      state_q, state_d;
  logic [31:0] hi_q, lo_q;
  logic        q_neg_q, r_neg_q;

  logic        is_mult, is_div, div_signed;
  logic        accept, zero_load, finish;
  logic [63:0] prod_u, product;
  logic signed [63:0] prod_s;
  logic        core_last;
  logic [31:0] quo_next, rem_next;

  assign is_mult    = (func == FunctMult) || (func == FunctMultu);
  assign is_div     = (func == FunctDiv) || (func == FunctDivu);
  assign div_signed = (func == FunctDiv);

  assign prod_u  = {32'b0, operand_1} * {32'b0, operand_2};
  assign prod_s  = $signed({{32{operand_1[31]}}, operand_1}) *
                   $signed({{32{operand_2[31]}}, operand_2});
  assign product = (func == FunctMult) ? prod_s : prod_u;

  mult_div_core u_core (
    .clk            (clk),
    .rst            (rst),
    .start          (accept),
    .step           (state_q == StDivBusy),
    .dividend       (abs_val(operand_1, div_signed)),
    .divisor        (abs_val(operand_2, div_signed)),
    .last           (core_last),
    .quotient_next  (quo_next),
    .remainder_next (rem_next)
  );

  always_comb begin
    state_d   = state_q;
    stall_req = 1'b0;
    done      = 1'b0;
    hi        = '0;
    lo        = '0;
    accept    = 1'b0;
    zero_load = 1'b0;
    finish    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (is_mult) begin
          done = 1'b1;
          hi   = product[63:32];
          lo   = product[31:0];
        end else if (is_div && !flush) begin
          stall_req = 1'b1;
          if (operand_2 == '0) begin
            zero_load = 1'b1;
            state_d   = StDivDone;
          end else begin
            accept  = 1'b1;
            state_d = StDivBusy;
          end
        end
      end
      StDivBusy: begin
        stall_req = 1'b1;
        if (flush) begin
          state_d = StIdle;
        end else if (core_last) begin
          finish  = 1'b1;
          state_d = StDivDone;
        end
      end
      StDivDone: begin
        state_d = StIdle;
        if (!flush) begin
          done = 1'b1;
          hi   = hi_q;
          lo   = lo_q;
        end
      end
      default: state_d = StIdle;
    endcase
    if (rst) begin
      stall_req = 1'b0;
      done      = 1'b0;
      hi        = '0;
      lo        = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      hi_q    <= '0;
      lo_q    <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        q_neg_q <= div_signed && (operand_1[31] ^ operand_2[31]);
        r_neg_q <= div_signed && operand_1[31];
      end
      if (zero_load) begin
        hi_q <= operand_1;
        lo_q <= 32'hFFFF_FFFF;
      end else if (finish) begin
        lo_q <= q_neg_q ? (~quo_next + 32'd1) : quo_next;
        hi_q <= r_neg_q ? (~rem_next + 32'd1) : rem_next;
      end
    end
  end

endmodule

// File: tb/tb_mult_div.sv
// Self-checking bench for mult_div: directed literal cases plus randomized traffic
// checked every cycle against an arithmetic reference model.
module tb_mult_div;

  localparam logic [5:0] FMult  = 6'h18;
  localparam logic [5:0] FMultu = 6'h19;
  localparam logic [5:0] FDiv   = 6'h1A;
  localparam logic [5:0] FDivu  = 6'h1B;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  func = 6'h0;
  logic [31:0] operand_1 = '0;
  logic [31:0] operand_2 = '0;
  logic        flush = 1'b0;
  logic        stall_req, done;
  logic [31:0] hi, lo;

  int vectors = 0;
  int miscompares = 0;

  mult_div dut (
    .clk       (clk),
    .rst       (rst),
    .func      (func),
    .operand_1 (operand_1),
    .operand_2 (operand_2),
    .flush     (flush),
    .stall_req (stall_req),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: 0 = idle, 1 = dividing (m_left cycles to go), 2 = result showing.
  int          m_state = 0;
  int          m_left = 0;
  logic [31:0] m_hi = '0, m_lo = '0;

  function automatic logic [63:0] ref_product(input logic [5:0] f, input logic [31:0] a,
                                              input logic [31:0] b);
    longint p;
    if (f == FMult) p = longint'($signed(a)) * longint'($signed(b));
    else            p = longint'({32'b0, a}) * longint'({32'b0, b});
    return 64'(p);
  endfunction

  always @(posedge clk) begin
    logic [63:0] q, r;
    if (rst || flush) begin
      m_state = 0;
    end else begin
      case (m_state)
        0: if (func == FDiv || func == FDivu) begin
          if (operand_2 == 0) begin
            m_lo = 32'hFFFF_FFFF;
            m_hi = operand_1;
            m_state = 2;
          end else begin
            if (func == FDiv) begin
              q = 64'(longint'($signed(operand_1)) / longint'($signed(operand_2)));
              r = 64'(longint'($signed(operand_1)) % longint'($signed(operand_2)));
            end else begin
              q = {32'b0, operand_1 / operand_2};
              r = {32'b0, operand_1 % operand_2};
            end
            m_lo = q[31:0];
            m_hi = r[31:0];
            m_state = 1;
            m_left = 32;
          end
        end
        1: begin
          m_left--;
          if (m_left == 0) m_state = 2;
        end
        default: m_state = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    logic        e_stall, e_done, chk_data;
    logic [31:0] e_hi, e_lo;
    logic [63:0] p;
    e_stall = 0; e_done = 0; e_hi = '0; e_lo = '0; chk_data = 1;
    if (!rst) begin
      case (m_state)
        0: if (func == FMult || func == FMultu) begin
          p = ref_product(func, operand_1, operand_2);
          e_done = 1; e_hi = p[63:32]; e_lo = p[31:0];
        end else if ((func == FDiv || func == FDivu) && !flush) begin
          e_stall = 1;
        end
        1: begin e_stall = 1; chk_data = 0; end
        default: if (!flush) begin e_done = 1; e_hi = m_hi; e_lo = m_lo; end
      endcase
    end
    check("stall_req", 64'(stall_req), 64'(e_stall));
    check("done", 64'(done), 64'(e_done));
    if (chk_data) check("hi_lo", {hi, lo}, {e_hi, e_lo});
  end

  task automatic run_div(input string name, input logic [5:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] elo, input logic [31:0] ehi,
                         input int elat);
    bit seen = 0;
    @(posedge clk); #1;
    flush = 0; func = f; operand_1 = a; operand_2 = b;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (i == 0) check({name, "_accept_stall"}, 64'(stall_req), 64'd1);
      if (done) begin
        seen = 1;
        check({name, "_latency"}, 64'(i), 64'(elat));
        check({name, "_lo"}, 64'(lo), 64'(elo));
        check({name, "_hi"}, 64'(hi), 64'(ehi));
      end else begin
        @(posedge clk); #1;
      end
    end
    if (!seen) check({name, "_timeout"}, 64'd0, 64'd1);
    @(posedge clk); #1;
    func = 6'h0;
  endtask

  initial begin
    func = FDivu; operand_1 = 32'd100; operand_2 = 32'd7;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {60'(hi) ^ 60'(lo), 1'b0, stall_req, done, |hi}, 64'd0);
    #1; rst = 0; func = 6'h0;
    @(negedge clk);
    check("idle_hi_lo", {hi, lo}, 64'd0);

    @(posedge clk); #1;
    func = FMult; operand_1 = 32'hFFFF_FFFF; operand_2 = 32'h2;
    @(negedge clk);
    check("mult_done", 64'(done), 64'd1);
    check("mult_stall", 64'(stall_req), 64'd0);
    check("mult_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFE);
    @(posedge clk); #1;
    func = FMultu;
    @(negedge clk);
    check("multu_hilo", {hi, lo}, 64'h0000_0001_FFFF_FFFE);

    run_div("divu_100_7", FDivu, 32'd100, 32'd7, 32'd14, 32'd2, 33);
    @(negedge clk);
    check("idle_after_divu", {62'd0, stall_req, done}, 64'd0);
    run_div("div_m7_2", FDiv, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33);
    run_div("div_min_m1", FDiv, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 33);
    run_div("div_5_0", FDiv, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1);

    // Flush ten cycles into a divide, then start a fresh one right after.
    @(posedge clk); #1;
    func = FDivu; operand_1 = 32'd1000; operand_2 = 32'd3;
    repeat (10) @(posedge clk);
    #1; flush = 1;
    @(negedge clk);
    check("flush_no_done", 64'(done), 64'd0);
    run_div("divu_9_3_after_flush", FDivu, 32'd9, 32'd3, 32'd3, 32'd0, 33);

    // Reset twenty cycles into a divide.
    @(posedge clk); #1;
    func = FDiv; operand_1 = 32'd12345; operand_2 = 32'd11;
    repeat (20) @(posedge clk);
    #1; rst = 1;
    @(negedge clk);
    check("rst_mid_outputs", {hi, lo ^ {30'd0, stall_req, done}}, 64'd0);
    @(posedge clk); #1; func = FMult; operand_1 = 32'd7; operand_2 = 32'd9;
    @(negedge clk);
    check("rst_mult_done", 64'(done), 64'd0);
    check("rst_mult_lo", 64'(lo), 64'd0);
    @(posedge clk); #1; rst = 0; func = 6'h0;
    @(negedge clk);
    check("after_rst_idle", {62'd0, stall_req, done}, 64'd0);

    for (int n = 0; n < 4000; n++) begin
      logic [31:0] pick [4];
      @(posedge clk); #1;
      pick[0] = 32'h0; pick[1] = 32'hFFFF_FFFF; pick[2] = 32'h8000_0000; pick[3] = $urandom;
      case ($urandom_range(0, 5))
        0: func = FMult;
        1: func = FMultu;
        2, 3: func = FDiv;
        4: func = FDivu;
        default: func = 6'($urandom);
      endcase
      operand_1 = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 3)] : $urandom;
      operand_2 = ($urandom_range(0, 7) == 0) ? 32'h0 :
                  ($urandom_range(0, 3) == 0) ? pick[$urandom_range(1, 3)] :
                  ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 300)) : $urandom;
      flush = ($urandom_range(0, 39) == 0);
      rst   = ($urandom_range(0, 199) == 0);
    end
    @(posedge clk); #1;
    rst = 0; flush = 0; func = 6'h0;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
